// File: rtl/ram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_pkg
// Description : Shared definitions for the PDP-11 style RAM bus initiator.
//               - Bus command encodings (DATI / DATO / DATIP / reserved)
//               - FSM state enumeration
//               - Read-latency bounds and latency-counter type
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bus_pkg;

  // Bus command encodings carried on cmd_i
  localparam logic [1:0] CMD_DATI  = 2'b00;  // read
  localparam logic [1:0] CMD_DATO  = 2'b01;  // write
  localparam logic [1:0] CMD_DATIP = 2'b10;  // read and lock for a following DATO
  localparam logic [1:0] CMD_RSVD  = 2'b11;  // reserved, always faults

  // Legal range of the RD_LAT parameter
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Latency counter holds RD_LAT-1 down to 0
  localparam int CNT_W = $clog2(RD_LAT_MAX);
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage : ram_bus_pkg
`default_nettype wire

// File: rtl/ram_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : ram_byte_lane
// Description : Combinational byte-lane steering between the 16-bit RAM port
//               and the requester.
//               Read side : picks the addressed byte (zero-extended) for byte
//                           reads, passes the whole word otherwise.
//               Write side: replicates the low byte onto both lanes for byte
//                           writes so the RAM can pick its lane from addr[0].
// Ports       : rd_addr0_i  - byte-address bit 0 of the read
//               rd_byte_i   - read is a byte access
//               rd_dout_i   - raw RAM read word
//               rd_rdata_o  - steered read data
//               wr_byte_i   - write is a byte access
//               wr_wdata_i  - requester write data
//               wr_din_o    - data to present on the RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_byte_lane (
  input  logic        rd_addr0_i,
  input  logic        rd_byte_i,
  input  logic [15:0] rd_dout_i,
  output logic [15:0] rd_rdata_o,
  input  logic        wr_byte_i,
  input  logic [15:0] wr_wdata_i,
  output logic [15:0] wr_din_o
);

  always_comb begin
    rd_rdata_o = rd_dout_i;
    if (rd_byte_i) begin
      rd_rdata_o = {8'h00, (rd_addr0_i ? rd_dout_i[15:8] : rd_dout_i[7:0])};
    end
  end

  always_comb begin
    wr_din_o = wr_wdata_i;
    if (wr_byte_i) begin
      wr_din_o = {wr_wdata_i[7:0], wr_wdata_i[7:0]};
    end
  end

endmodule : ram_byte_lane
`default_nettype wire

// File: rtl/ram_sync.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync
// Description : Synchronous 16-bit word RAM with byte-write capability.
//               Reads register the addressed word on every edge with rd_i
//               high; writes update the whole word, or only the lane chosen
//               by addr_i[0] when byte_i is set.
// Ports       : clk_i  - clock
//               rd_i   - read strobe
//               wr_i   - write strobe
//               byte_i - byte-operation qualifier
//               addr_i - byte address
//               din_i  - write data
//               dout_o - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rd_i,
  input  logic          wr_i,
  input  logic          byte_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   din_i,
  output logic [15:0]   dout_o
);

  logic [15:0] mem_q [2**(AW-1)];

  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      if (!byte_i) begin
        mem_q[addr_i[AW-1:1]] <= din_i;
      end else if (addr_i[0]) begin
        mem_q[addr_i[AW-1:1]][15:8] <= din_i[15:8];
      end else begin
        mem_q[addr_i[AW-1:1]][7:0] <= din_i[7:0];
      end
    end
    if (rd_i) begin
      dout_o <= mem_q[addr_i[AW-1:1]];
    end
  end

endmodule : ram_sync
`default_nettype wire

// File: rtl/ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_master
// Description : Bus initiator driving a synchronous 16-bit word RAM for one
//               DATI / DATO / DATIP request at a time. Handles byte-lane
//               steering, odd-address word faults, reserved-command faults
//               and the DATIP->DATO read-modify-write lock. Completes every
//               accepted request with a single-cycle response.
// Ports       : clk_i, reset_i            - clock, async active-high reset
//               req_i, cmd_i, req_byte_i,
//               req_addr_i, req_wdata_i   - request (accepted on req_i & ready_o)
//               ready_o                   - able to accept a request
//               rsp_valid_o, rsp_rdata_o,
//               rsp_err_o                 - single-cycle response
//               locked_o                  - DATIP done, matching DATO pending
//               ram_addr_o, ram_din_o,
//               ram_dout_i, ram_rd_o,
//               ram_wr_o, ram_byte_o      - RAM port (strobes registered)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_master #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [1:0]  cmd_i,
  input  logic        req_byte_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        ready_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        locked_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_din_o,
  input  logic [15:0] ram_dout_i,
  output logic        ram_rd_o,
  output logic        ram_wr_o,
  output logic        ram_byte_o
);

  import ram_bus_pkg::*;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [1:0]  cmd_q;
  logic        lock_q, lock_d;
  logic [15:0] ram_addr_q, ram_din_q;
  logic        ram_byte_q, ram_rd_q, ram_wr_q;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        can_accept;
  logic        accept;
  logic        lock_match;
  logic        fault;
  logic [15:0] lane_rdata;
  logic [15:0] lane_din;

  // Read steering works on the latched request; write replication works on
  // the incoming request so the RAM data is ready in the WRITE cycle.
  ram_byte_lane u_lane (
    .rd_addr0_i (ram_addr_q[0]),
    .rd_byte_i  (ram_byte_q),
    .rd_dout_i  (ram_dout_i),
    .rd_rdata_o (lane_rdata),
    .wr_byte_i  (req_byte_i),
    .wr_wdata_i (req_wdata_i),
    .wr_din_o   (lane_din)
  );

  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign accept     = req_i & can_accept;

  // While locked, ram_addr_q/ram_byte_q still hold the DATIP's address and
  // size because nothing else has been accepted since it.
  assign lock_match = (cmd_i == CMD_DATO) && (req_addr_i == ram_addr_q) &&
                      (req_byte_i == ram_byte_q);

  assign fault = (!req_byte_i && req_addr_i[0]) ||
                 (cmd_i == CMD_RSVD) ||
                 (lock_q && !lock_match);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_DATI;
      lock_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_byte_q  <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      // Strobes follow the state being entered so they are flop outputs
      // aligned with the READ/WRITE cycles.
      ram_rd_q    <= (state_d == ST_READ);
      ram_wr_q    <= (state_d == ST_WRITE);
      if (accept) begin
        cmd_q      <= cmd_i;
        ram_addr_q <= req_addr_i;
        ram_byte_q <= req_byte_i;
        if ((cmd_i == CMD_DATO) && !fault) begin
          ram_din_q <= lane_din;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (fault) begin
            state_d = ST_RESP;
          end else if (cmd_i == CMD_DATO) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = cnt_t'(RD_LAT - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_WRITE:   state_d = ST_RESP;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Response data, error flag and lock updates
  always_comb begin
    rsp_err_d   = accept && fault;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == ST_CAPTURE) begin
      rsp_rdata_d = lane_rdata;
    end else if (accept) begin
      rsp_rdata_d = '0;
    end

    lock_d = lock_q;
    if (accept && fault) begin
      lock_d = 1'b0;
    end else if ((state_q == ST_CAPTURE) && (cmd_q == CMD_DATIP)) begin
      lock_d = 1'b1;
    end else if (state_q == ST_WRITE) begin
      // A DATO only reaches WRITE while locked if it was the matching one.
      lock_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ready_o     = can_accept;
    rsp_valid_o = (state_q == ST_RESP);
    rsp_rdata_o = rsp_rdata_q;
    rsp_err_o   = rsp_err_q;
    locked_o    = lock_q;
    ram_addr_o  = ram_addr_q;
    ram_din_o   = ram_din_q;
    ram_rd_o    = ram_rd_q;
    ram_wr_o    = ram_wr_q;
    ram_byte_o  = ram_byte_q;
  end

endmodule : ram_bus_master
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_bus_master
// Description : Self-checking bench for ram_bus_master. Two instances are
//               built, RD_LAT=1 and RD_LAT=3, each against its own ram_sync.
//               Directed table vectors, hand-written multi-cycle sequences
//               and randomized traffic checked against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_master;
  import ram_bus_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  cmd     [2];
  logic [1:0]  rbyte;
  logic [15:0] raddr   [2];
  logic [15:0] rwdata  [2];
  logic [1:0]  ready, rsp_valid, rsp_err, locked, ram_rd, ram_wr, ram_byte;
  logic [15:0] rsp_rdata [2];
  logic [15:0] ram_addr  [2];
  logic [15:0] ram_din   [2];
  logic [15:0] ram_dout  [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_bus_master #(.RD_LAT(g == 0 ? LAT0 : LAT1)) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_i       (req[g]),
      .cmd_i       (cmd[g]),
      .req_byte_i  (rbyte[g]),
      .req_addr_i  (raddr[g]),
      .req_wdata_i (rwdata[g]),
      .ready_o     (ready[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g]),
      .locked_o    (locked[g]),
      .ram_addr_o  (ram_addr[g]),
      .ram_din_o   (ram_din[g]),
      .ram_dout_i  (ram_dout[g]),
      .ram_rd_o    (ram_rd[g]),
      .ram_wr_o    (ram_wr[g]),
      .ram_byte_o  (ram_byte[g])
    );
    ram_sync u_ram (
      .clk_i  (clk),
      .rd_i   (ram_rd[g]),
      .wr_i   (ram_wr[g]),
      .byte_i (ram_byte[g]),
      .addr_i (ram_addr[g]),
      .din_i  (ram_din[g]),
      .dout_o (ram_dout[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // ---------------- reference model: byte memory + lock ----------------
  logic [7:0]  mem_m  [2][65536];
  logic        m_lock [2];
  logic [15:0] m_laddr[2];
  logic        m_lbyte[2];

  task automatic model_txn(input int d, input logic [1:0] c, input logic b,
                           input logic [15:0] a, input logic [15:0] w,
                           output logic e_err, output logic [15:0] e_rd,
                           output int e_lat, output logic e_isrd, output logic e_iswr);
    logic [15:0] aw;
    aw     = {a[15:1], 1'b0};
    e_rd   = '0;
    e_isrd = 1'b0;
    e_iswr = 1'b0;
    e_err  = (!b && a[0]) || (c == CMD_RSVD) ||
             (m_lock[d] && !(c == CMD_DATO && a == m_laddr[d] && b == m_lbyte[d]));
    if (e_err) begin
      m_lock[d] = 1'b0;
      e_lat     = 1;
    end else if (c == CMD_DATO) begin
      if (b) mem_m[d][a] = w[7:0];
      else begin
        mem_m[d][aw]         = w[7:0];
        mem_m[d][aw | 16'h1] = w[15:8];
      end
      m_lock[d] = 1'b0;
      e_lat     = 2;
      e_iswr    = 1'b1;
    end else begin
      e_rd   = b ? {8'h00, mem_m[d][a]} : {mem_m[d][aw | 16'h1], mem_m[d][aw]};
      e_lat  = lat_of(d) + 2;
      e_isrd = 1'b1;
      if (c == CMD_DATIP) begin
        m_lock[d]  = 1'b1;
        m_laddr[d] = a;
        m_lbyte[d] = b;
      end
    end
  endtask

  // Issue one request (from a negedge, back-to-back if ready is already high)
  // and watch the bus until the response; returns at the RESP-cycle negedge.
  task automatic run_txn(input int d, input logic [1:0] c, input logic b,
                         input logic [15:0] a, input logic [15:0] w,
                         output int lat, output logic [15:0] rdata, output logic err,
                         output int rdn, output int wrn, output int first_rd,
                         output logic bad);
    int k;
    k = 0;
    while (!ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", 32'(ready[d]), 32'd1);
    req[d] = 1'b1; cmd[d] = c; rbyte[d] = b; raddr[d] = a; rwdata[d] = w;
    @(posedge clk);
    #1 req[d] = 1'b0;
    lat = 0; rdata = '0; err = 1'b0; rdn = 0; wrn = 0; first_rd = 0; bad = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (ram_rd[d]) begin
        rdn++;
        if (first_rd == 0) first_rd = j;
        if (ram_addr[d] !== a || ram_byte[d] !== b) bad = 1'b1;
      end
      if (ram_wr[d]) begin
        wrn++;
        if (ram_addr[d] !== a || ram_byte[d] !== b ||
            ram_din[d] !== (b ? {w[7:0], w[7:0]} : w)) bad = 1'b1;
      end
      if (ram_rd[d] && ram_wr[d]) bad = 1'b1;
      if (rsp_valid[d]) begin
        lat   = j;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        break;
      end
    end
  endtask

  task automatic txn_check(input int d, input logic [1:0] c, input logic b,
                           input logic [15:0] a, input logic [15:0] w, input string tag,
                           output logic act_err, output logic [15:0] act_rd);
    logic e_err, e_isrd, e_iswr, bad;
    logic [15:0] e_rd;
    int e_lat, lat, rdn, wrn, first_rd;
    model_txn(d, c, b, a, w, e_err, e_rd, e_lat, e_isrd, e_iswr);
    run_txn(d, c, b, a, w, lat, act_rd, act_err, rdn, wrn, first_rd, bad);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(act_err), 32'(e_err));
    if (e_isrd) begin
      chk({tag, "_rdata"}, 32'(act_rd), 32'(e_rd));
      chk({tag, "_rd_start"}, 32'(first_rd), 32'd1);
    end
    chk({tag, "_rd_cycles"}, 32'(rdn), e_isrd ? 32'(lat_of(d)) : 32'd0);
    chk({tag, "_wr_cycles"}, 32'(wrn), e_iswr ? 32'd1 : 32'd0);
    chk({tag, "_bus_ok"}, 32'(bad), 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  c;
    logic        b;
    logic [15:0] a;
    logic [15:0] w;
    logic        e_err;
    logic        chk_rd;
    logic [15:0] e_rd;
    logic        e_lock;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] c, input logic b, input logic [15:0] a,
                     input logic [15:0] w, input logic e_err, input logic chk_rd,
                     input logic [15:0] e_rd, input logic e_lock);
    vec_t v;
    v.c = c; v.b = b; v.a = a; v.w = w;
    v.e_err = e_err; v.chk_rd = chk_rd; v.e_rd = e_rd; v.e_lock = e_lock;
    tbl.push_back(v);
  endtask

  logic        act_err;
  logic [15:0] act_rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, rdn, wrn, frd;
    logic bad, seen;
    logic [1:0] c;
    logic b;
    logic [15:0] a, w;

    reset = 1'b0; req = '0; rbyte = '0;
    for (int d = 0; d < 2; d++) begin
      cmd[d] = '0; raddr[d] = '0; rwdata[d] = '0; m_lock[d] = 1'b0;
      m_laddr[d] = '0; m_lbyte[d] = 1'b0;
    end
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(ready[d]), 32'd1);
      chk($sformatf("rst%0d_locked", d), 32'(locked[d]), 32'd0);
      chk($sformatf("rst%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst%0d_rsp_err", d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("rst%0d_rsp_rdata", d), 32'(rsp_rdata[d]), 32'd0);
      chk($sformatf("rst%0d_ram_rd", d), 32'(ram_rd[d]), 32'd0);
      chk($sformatf("rst%0d_ram_wr", d), 32'(ram_wr[d]), 32'd0);
      chk($sformatf("rst%0d_ram_byte", d), 32'(ram_byte[d]), 32'd0);
      chk($sformatf("rst%0d_ram_addr", d), 32'(ram_addr[d]), 32'd0);
      chk($sformatf("rst%0d_ram_din", d), 32'(ram_din[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors on the RD_LAT=1 instance
    add(CMD_DATO,  0, 16'o001000, 16'o123456, 0, 0, 16'h0000, 0);
    add(CMD_DATI,  0, 16'o001000, 16'h0000,   0, 1, 16'o123456, 0);
    add(CMD_DATO,  0, 16'o002000, 16'hA5C3,   0, 0, 16'h0000, 0);
    add(CMD_DATO,  1, 16'o002001, 16'h337E,   0, 0, 16'h0000, 0);
    add(CMD_DATI,  0, 16'o002000, 16'h0000,   0, 1, 16'h7EC3, 0);
    add(CMD_DATI,  1, 16'o002000, 16'h0000,   0, 1, 16'h00C3, 0);
    add(CMD_DATI,  1, 16'o002001, 16'h0000,   0, 1, 16'h007E, 0);
    add(CMD_DATI,  0, 16'o003001, 16'h0000,   1, 0, 16'h0000, 0);
    add(CMD_DATO,  0, 16'o004000, 16'h1111,   0, 0, 16'h0000, 0);
    add(CMD_DATIP, 0, 16'o004000, 16'h0000,   0, 1, 16'h1111, 1);
    add(CMD_DATO,  0, 16'o004000, 16'h2222,   0, 0, 16'h0000, 0);
    add(CMD_DATI,  0, 16'o004000, 16'h0000,   0, 1, 16'h2222, 0);
    add(CMD_DATIP, 0, 16'o004000, 16'h0000,   0, 1, 16'h2222, 1);
    add(CMD_DATI,  0, 16'o004000, 16'h0000,   1, 0, 16'h0000, 0);
    add(CMD_DATI,  0, 16'o004000, 16'h0000,   0, 1, 16'h2222, 0);
    add(CMD_RSVD,  0, 16'o004000, 16'h0000,   1, 0, 16'h0000, 0);
    add(CMD_DATIP, 1, 16'o004001, 16'h0000,   0, 1, 16'h0022, 1);
    add(CMD_DATO,  0, 16'o004000, 16'h5555,   1, 0, 16'h0000, 0);
    add(CMD_DATI,  0, 16'o004000, 16'h0000,   0, 1, 16'h2222, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      txn_check(0, tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].w, $sformatf("tbl%0d", i),
                act_err, act_rd);
      chk($sformatf("tbl%0d_vec_err", i), 32'(act_err), 32'(tbl[i].e_err));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_vec_rdata", i), 32'(act_rd), 32'(tbl[i].e_rd));
      @(negedge clk);
      chk($sformatf("tbl%0d_locked", i), 32'(locked[0]), 32'(tbl[i].e_lock));
    end

    // Back-to-back on the RD_LAT=3 instance: writes then four chained reads,
    // each issued in the previous response cycle.
    for (int i = 0; i < 4; i++)
      txn_check(1, CMD_DATO, 0, 16'h0100 + 16'(2 * i), 16'hC000 + 16'(i * 16'h0111),
                $sformatf("b2b_wr%0d", i), act_err, act_rd);
    for (int i = 0; i < 4; i++)
      txn_check(1, CMD_DATI, 0, 16'h0100 + 16'(2 * i), 16'h0000,
                $sformatf("b2b_rd%0d", i), act_err, act_rd);
    @(negedge clk);

    // Reset in the middle of a read on the RD_LAT=3 instance
    req[1] = 1'b1; cmd[1] = CMD_DATI; rbyte[1] = 1'b0; raddr[1] = 16'h0100;
    @(posedge clk);
    #1 req[1] = 1'b0;
    #1 chk("midrst_rd_before", 32'(ram_rd[1]), 32'd1);
    reset = 1'b1;
    #1 chk("midrst_rd_drop", 32'(ram_rd[1]), 32'd0);
    chk("midrst_valid_drop", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_lock[0] = 1'b0;
    m_lock[1] = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (rsp_valid[1] || ram_rd[1]) seen = 1'b1;
    end
    chk("midrst_no_response", 32'(seen), 32'd0);
    chk("midrst_ready", 32'(ready[1]), 32'd1);
    chk("midrst_locked", 32'(locked[1]), 32'd0);
    txn_check(1, CMD_DATI, 0, 16'h0102, 16'h0000, "midrst_next", act_err, act_rd);
    @(negedge clk);

    // Randomized traffic against the model on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        txn_check(d, CMD_DATO, 0, 16'h3000 + 16'(2 * i), 16'($urandom),
                  $sformatf("init%0d_%0d", d, i), act_err, act_rd);
      for (int i = 0; i < 150; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        c = (r < 4) ? CMD_DATI : (r < 7) ? CMD_DATO : (r < 9) ? CMD_DATIP : CMD_RSVD;
        b = 1'($urandom);
        a = 16'h3000 + 16'($urandom_range(0, 31));
        w = 16'($urandom);
        if (m_lock[d] && ($urandom_range(0, 3) != 0)) begin
          c = CMD_DATO;
          a = m_laddr[d];
          b = m_lbyte[d];
        end
        txn_check(d, c, b, a, w, $sformatf("rnd%0d_%0d", d, i), act_err, act_rd);
        if ($urandom_range(0, 1) == 1) begin
          @(negedge clk);
          chk($sformatf("rnd%0d_%0d_locked", d, i), 32'(locked[d]), 32'(m_lock[d]));
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_bus_master
`default_nettype wire
